butt_seq_ctrl: RTL and testbench
================================

BUTT_SEQ_CTRL -- requirements
Module: butt_seq_ctrl

Interface
REQ-001 Parameter Stage, default 8, digit count of filter; data width WL = 2*Stage.
REQ-002 Parameter LAT, default 1, cycles from filt_din accepted (filt_enable=1) to matching filt_dout.
REQ-003 Parameter FLUSH_CYC, default 2, cycles filt_enable held low before a run to clear filter state.
REQ-004 Parameter DISCARD, default 0, leading outputs of a run suppressed as settling.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  begin a run when idle.
REQ-008 stop  in  1  end sample intake early.
REQ-009 num_samples  in  16  samples per run, sampled on start.
REQ-010 in_valid / in_ready / in_data  in / out / in  1/1/WL  sample intake handshake.
REQ-011 filt_enable  out  1  drives filter enable.
REQ-012 filt_din  out  WL  sample to filter.
REQ-013 filt_dout  in  WL  filter output.
REQ-014 out_valid / out_data / out_last  out  1/WL/1  filtered result stream, no backpressure.
REQ-015 busy / done / underrun  out  1/1/1  status; done is a 1-cycle pulse; underrun is sticky per run.
REQ-016 issued_cnt  out  16  samples issued in current run.

Function
REQ-017 FSM states IDLE, FLUSH, RUN, DRAIN, DONE; busy=1 in all states except IDLE.
REQ-018 IDLE: start=1 with num_samples!=0 -> FLUSH, latch num_samples, clear issued_cnt and underrun; with num_samples=0 -> DONE.
REQ-019 FLUSH: filt_enable=0, filt_din=0 for exactly FLUSH_CYC cycles, then RUN.
REQ-020 RUN: filt_enable=1 and in_ready=1 every cycle; one sample issued per cycle.
REQ-021 RUN, in_valid=1: filt_din=in_data, transfer occurs.
REQ-022 RUN, in_valid=0: filt_din=0 issued as sample, underrun set; enable never drops mid-run (drop would clear filter recursion).
REQ-023 RUN exits to DRAIN after cycle issuing sample num_samples, or the cycle stop=1 (that cycle's sample still issued).
REQ-024 DRAIN: filt_enable=1, filt_din=0, in_ready=0, for LAT cycles, then DONE.
REQ-025 DONE: done=1 one cycle, filt_enable=0, then IDLE; start ignored in FLUSH/RUN/DRAIN/DONE.
REQ-026 in_ready=0 outside RUN; filt_enable=0 in IDLE, FLUSH, DONE.
REQ-027 Each issued sample enters a LAT-deep tag pipeline (valid, index, last); tag exit aligns with filt_dout.
REQ-028 out_valid=1 when exiting tag valid and index >= DISCARD; out_data=filt_dout that cycle, else 0.
REQ-029 out_last=1 with out_valid for final issued sample; if final index < DISCARD, no out_last, done still pulses.
REQ-030 issued_cnt increments per issued sample, saturates at 16'hFFFF, holds after run until next start.

Reset
REQ-031 rst=1 at any clock edge: state IDLE, filt_enable=0, filt_din=0, in_ready=0, out_valid/out_last/out_data=0, done=0, busy=0, underrun=0, issued_cnt=0, tag pipeline cleared.
REQ-032 rst mid-run abandons run with no done pulse; rst wins over start/stop in same cycle.

Structure
REQ-033 State encoding and WL derivation in shared package butt_pkg alongside filter width constants.
REQ-034 One sub-module natural: butt_tag_pipe (LAT-deep valid/index/last shift register).

Verification
REQ-035 Stage=8,LAT=1,FLUSH_CYC=2: start, num_samples=4, in_valid always 1 -> enable low 2 cycles, 4 samples issued, 4 out_valid one cycle later, out_last on 4th, done next.
REQ-036 num_samples=5, in_valid low on 3rd RUN cycle -> filt_din=0 that cycle, underrun=1, issued_cnt=5, 5 outputs.
REQ-037 num_samples=100, stop at 10th RUN cycle -> issued_cnt=10, out_last on 10th output, done pulses.
REQ-038 start with num_samples=0 -> DONE next cycle, done=1, no enable, no outputs.
REQ-039 DISCARD=2, num_samples=4 -> only outputs 3,4 valid; out_last on 4th.
REQ-040 rst asserted mid-RUN -> next cycle all outputs zero, state IDLE, no done; new start runs cleanly.

Source files
------------

// File: rtl/butt_pkg.sv
// Shared definitions for the butterfly-filter sequencer: state encoding,
// width derivation and the tag record that travels alongside filter latency.
package butt_pkg;

    localparam int STAGE_DEF   = 8;
    localparam int LAT_DEF     = 1;
    localparam int FLUSH_DEF   = 2;
    localparam int DISCARD_DEF = 0;
    localparam int CNT_W       = 16;

    // Filter data width is two bits per digit stage.
    function automatic int wl_of(input int stage);
        return 2 * stage;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic             valid;
        logic             last;
        logic [CNT_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/butt_seq_ctrl_if.sv
// Sample intake and filtered-result stream between the sequencer and its user.
// Intake: a sample transfers on a rising edge where in_valid && in_ready; the
// result stream has no backpressure, out_data/out_last qualify with out_valid.
interface butt_seq_ctrl_if #(
    parameter int WL = butt_pkg::wl_of(butt_pkg::STAGE_DEF)
);
    logic          in_valid;
    logic          in_ready;
    logic [WL-1:0] in_data;
    logic          out_valid;
    logic [WL-1:0] out_data;
    logic          out_last;

    modport slave (
        input  in_valid, in_data,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/butt_tag_pipe.sv
// LAT-deep shift register of sample tags; the exit stage lines up with the
// filter output produced from the sample that entered LAT cycles earlier.
module butt_tag_pipe
    import butt_pkg::*;
#(
    parameter int LAT = LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t pipe_q [LAT];
    tag_t pipe_d [LAT];

    always_comb begin
        pipe_d[0] = tag_i;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_o = pipe_q[LAT-1];

endmodule

// File: rtl/butt_seq_ctrl.sv
// Run sequencer for a recursive digit filter: flushes filter state, streams a
// fixed number of samples with enable held high, drains latency, then reports.
module butt_seq_ctrl
    import butt_pkg::*;
#(
    parameter  int Stage     = STAGE_DEF,
    parameter  int LAT       = LAT_DEF,
    parameter  int FLUSH_CYC = FLUSH_DEF,
    parameter  int DISCARD   = DISCARD_DEF,
    localparam int WL        = wl_of(Stage)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] num_samples,
    butt_seq_ctrl_if.slave   s,
    output logic             filt_enable,
    output logic [WL-1:0]    filt_din,
    input  logic [WL-1:0]    filt_dout,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    output logic [CNT_W-1:0] issued_cnt,
    output state_e           state_dbg
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ph_q, ph_d;
    logic             under_q, under_d;
    logic             in_ready_c;
    logic             issue;
    logic             last;
    tag_t             tag_in;
    tag_t             tag_out;
    logic             keep;

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        cnt_d       = cnt_q;
        ph_d        = ph_q;
        under_d     = under_q;
        in_ready_c  = 1'b0;
        issue       = 1'b0;
        last        = 1'b0;
        filt_enable = 1'b0;
        filt_din    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_d   = num_samples;
                    cnt_d   = '0;
                    ph_d    = '0;
                    under_d = 1'b0;
                    if (num_samples == '0)  state_d = ST_DONE;
                    else if (FLUSH_CYC == 0) state_d = ST_RUN;
                    else                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                ph_d = ph_q + 1'b1;
                if (ph_q == CNT_W'(FLUSH_CYC - 1)) begin
                    ph_d    = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A missing sample is replaced by zero: dropping enable here
                // would wipe the filter recursion mid-run.
                filt_enable = 1'b1;
                in_ready_c  = 1'b1;
                issue       = 1'b1;
                filt_din    = s.in_valid ? s.in_data : '0;
                if (!s.in_valid)  under_d = 1'b1;
                if (cnt_q != '1)  cnt_d   = cnt_q + 1'b1;
                last = stop || (({1'b0, cnt_q} + 17'd1) == {1'b0, num_q});
                if (last) begin
                    ph_d    = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                filt_enable = 1'b1;
                ph_d        = ph_q + 1'b1;
                if (ph_q == CNT_W'(LAT - 1)) begin
                    ph_d    = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            num_q   <= '0;
            cnt_q   <= '0;
            ph_q    <= '0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            under_q <= under_d;
        end
    end

    // Index is the pre-increment count, so the first sample of a run is 0.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = issue;
        tag_in.last  = issue & last;
        tag_in.idx   = issue ? cnt_q : '0;
    end

    butt_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    if (DISCARD == 0) begin : g_keep_all
        assign keep = 1'b1;
    end else begin : g_keep_cmp
        assign keep = (tag_out.idx >= CNT_W'(DISCARD));
    end

    assign s.in_ready  = in_ready_c;
    assign s.out_valid = tag_out.valid & keep;
    assign s.out_data  = (tag_out.valid & keep) ? filt_dout : '0;
    assign s.out_last  = tag_out.valid & keep & tag_out.last;

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign underrun   = under_q;
    assign issued_cnt = cnt_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_butt_seq_ctrl.sv
// Bench for butt_seq_ctrl: two instances (DISCARD 0 and 2) share one stimulus
// stream; each has a one-cycle filter stub and its own expected-output queue.
module tb_butt_seq_ctrl;
    import butt_pkg::*;

    localparam int WL = 16;

    typedef struct {
        int num;
        int stop_at;
        int gap_at;
        bit start_mid;
        int exp_issued;
        bit exp_under;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [CNT_W-1:0] num_samples = '0;

    logic             fe0, fe1, busy0, busy1, done0, done1, under0, under1;
    logic [WL-1:0]    fdin0, fdin1;
    logic [WL-1:0]    fq0 = '0;
    logic [WL-1:0]    fq1 = '0;
    logic [CNT_W-1:0] cnt0, cnt1;
    state_e           st0, st1;

    logic [WL:0] exp_q0[$];
    logic [WL:0] exp_q1[$];
    int chk_cnt = 0;
    int fail_cnt = 0;
    int out_cnt0 = 0;
    int out_cnt1 = 0;
    bit mon_en = 1'b0;

    butt_seq_ctrl_if #(.WL(WL)) if0 ();
    butt_seq_ctrl_if #(.WL(WL)) if1 ();

    assign if1.in_valid = if0.in_valid;
    assign if1.in_data  = if0.in_data;

    always #5 clk = ~clk;

    butt_seq_ctrl #(.Stage(8), .LAT(1), .FLUSH_CYC(2), .DISCARD(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .num_samples(num_samples),
        .s(if0), .filt_enable(fe0), .filt_din(fdin0), .filt_dout(fq0),
        .busy(busy0), .done(done0), .underrun(under0), .issued_cnt(cnt0), .state_dbg(st0)
    );

    butt_seq_ctrl #(.Stage(8), .LAT(1), .FLUSH_CYC(2), .DISCARD(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .num_samples(num_samples),
        .s(if1), .filt_enable(fe1), .filt_din(fdin1), .filt_dout(fq1),
        .busy(busy1), .done(done1), .underrun(under1), .issued_cnt(cnt1), .state_dbg(st1)
    );

    // One-cycle filter stub: output = accepted input + 0x0101.
    always @(posedge clk) begin
        if (fe0) fq0 <= fdin0 + 16'h0101;
        if (fe1) fq1 <= fdin1 + 16'h0101;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic [WL:0] e;
            if (if0.out_valid) begin
                chk("out0_expected_pending", 32'(exp_q0.size() != 0), 32'd1);
                if (exp_q0.size() != 0) begin
                    e = exp_q0.pop_front();
                    chk("out0_data", 32'(if0.out_data), 32'(e[WL-1:0]));
                    chk("out0_last", 32'(if0.out_last), 32'(e[WL]));
                end
                out_cnt0++;
            end else begin
                chk("out0_idle_zero", {15'd0, if0.out_last, if0.out_data}, 32'd0);
            end
            if (if1.out_valid) begin
                chk("out1_expected_pending", 32'(exp_q1.size() != 0), 32'd1);
                if (exp_q1.size() != 0) begin
                    e = exp_q1.pop_front();
                    chk("out1_data", 32'(if1.out_data), 32'(e[WL-1:0]));
                    chk("out1_last", 32'(if1.out_last), 32'(e[WL]));
                end
                out_cnt1++;
            end else begin
                chk("out1_idle_zero", {15'd0, if1.out_last, if1.out_data}, 32'd0);
            end
        end
    end

    task automatic check_idle(input string nm);
        chk({nm, "_state"}, 32'(st0), 32'(ST_IDLE));
        chk({nm, "_state1"}, 32'(st1), 32'(ST_IDLE));
        chk({nm, "_busy"}, 32'(busy0), 32'd0);
        chk({nm, "_done"}, 32'(done0 | done1), 32'd0);
        chk({nm, "_enable"}, 32'(fe0), 32'd0);
        chk({nm, "_din"}, 32'(fdin0), 32'd0);
        chk({nm, "_in_ready"}, 32'(if0.in_ready), 32'd0);
    endtask

    // Drives one run on the bench's own timeline: 2 flush cycles, exp_issued
    // run cycles, 1 drain cycle, 1 done cycle.
    task automatic run_case(input vec_t v);
        logic          vld;
        logic [WL-1:0] d;
        logic [WL-1:0] e;
        int            n1;
        @(negedge clk);
        start = 1'b1;
        num_samples = CNT_W'(v.num);
        out_cnt0 = 0;
        out_cnt1 = 0;
        @(negedge clk);
        start = 1'b0;
        num_samples = 16'h0003;
        if (v.num == 0) begin
            #1;
            chk("zero_state_done", 32'(st0), 32'(ST_DONE));
            chk("zero_done", 32'(done0), 32'd1);
            chk("zero_enable", 32'(fe0), 32'd0);
        end else begin
            for (int f = 0; f < 2; f++) begin
                if (f == 1) @(negedge clk);
                #1;
                chk("flush_state", 32'(st0), 32'(ST_FLUSH));
                chk("flush_enable", 32'(fe0), 32'd0);
                chk("flush_din", 32'(fdin0), 32'd0);
                chk("flush_in_ready", 32'(if0.in_ready), 32'd0);
                chk("flush_busy", 32'(busy0), 32'd1);
            end
            for (int i = 0; i < v.exp_issued; i++) begin
                @(negedge clk);
                vld = (i != v.gap_at);
                d = WL'($urandom_range(0, 65535));
                if0.in_valid = vld;
                if0.in_data = d;
                stop = (v.stop_at > 0) && (i == v.stop_at - 1);
                start = v.start_mid && (i == 1);
                #1;
                chk("run_state", 32'(st0), 32'(ST_RUN));
                chk("run_enable", 32'(fe0), 32'd1);
                chk("run_in_ready", 32'(if0.in_ready), 32'd1);
                chk("run_din", 32'(fdin0), 32'(vld ? d : '0));
                e = (vld ? d : '0) + 16'h0101;
                exp_q0.push_back({(i == v.exp_issued - 1), e});
                if (i >= 2) exp_q1.push_back({(i == v.exp_issued - 1), e});
            end
            @(negedge clk);
            if0.in_valid = 1'b0;
            stop = 1'b0;
            start = 1'b0;
            #1;
            chk("drain_state", 32'(st0), 32'(ST_DRAIN));
            chk("drain_enable", 32'(fe0), 32'd1);
            chk("drain_din", 32'(fdin0), 32'd0);
            chk("drain_in_ready", 32'(if0.in_ready), 32'd0);
            @(negedge clk);
            #1;
            chk("done_state", 32'(st0), 32'(ST_DONE));
            chk("done_pulse", 32'(done0), 32'd1);
            chk("done_pulse_d2", 32'(done1), 32'd1);
            chk("done_enable", 32'(fe0), 32'd0);
        end
        chk("issued_cnt", 32'(cnt0), 32'(v.exp_issued));
        chk("underrun", 32'(under0), 32'(v.exp_under));
        @(negedge clk);
        #1;
        check_idle("after_run");
        chk("issued_hold", 32'(cnt0), 32'(v.exp_issued));
        chk("issued_hold_d2", 32'(cnt1), 32'(v.exp_issued));
        chk("queue0_empty", 32'(exp_q0.size()), 32'd0);
        chk("queue1_empty", 32'(exp_q1.size()), 32'd0);
        chk("out_count0", 32'(out_cnt0), 32'(v.exp_issued));
        n1 = (v.exp_issued > 2) ? v.exp_issued - 2 : 0;
        chk("out_count1", 32'(out_cnt1), 32'(n1));
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{num: 4,   stop_at: 0,  gap_at: -1, start_mid: 0, exp_issued: 4,  exp_under: 0};
        vecs[1] = '{num: 5,   stop_at: 0,  gap_at: 2,  start_mid: 0, exp_issued: 5,  exp_under: 1};
        vecs[2] = '{num: 100, stop_at: 10, gap_at: -1, start_mid: 0, exp_issued: 10, exp_under: 0};
        vecs[3] = '{num: 0,   stop_at: 0,  gap_at: -1, start_mid: 0, exp_issued: 0,  exp_under: 0};
        vecs[4] = '{num: 1,   stop_at: 0,  gap_at: -1, start_mid: 0, exp_issued: 1,  exp_under: 0};
        vecs[5] = '{num: 3,   stop_at: 1,  gap_at: 0,  start_mid: 0, exp_issued: 1,  exp_under: 1};
        vecs[6] = '{num: 2,   stop_at: 0,  gap_at: -1, start_mid: 1, exp_issued: 2,  exp_under: 0};
        vecs[7] = '{num: 6,   stop_at: 0,  gap_at: 5,  start_mid: 1, exp_issued: 6,  exp_under: 1};
        vecs[8] = '{num: 9,   stop_at: 0,  gap_at: 0,  start_mid: 0, exp_issued: 9,  exp_under: 1};

        if0.in_valid = 1'b0;
        if0.in_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        #1;
        check_idle("reset");
        chk("reset_underrun", 32'(under0), 32'd0);
        chk("reset_issued", 32'(cnt0), 32'd0);

        for (int k = 0; k < 9; k++) begin
            run_case(vecs[k]);
        end

        // Reset in the middle of a run, asserted together with start.
        @(negedge clk);
        start = 1'b1;
        num_samples = 16'd20;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            logic [WL-1:0] d;
            @(negedge clk);
            d = WL'($urandom_range(0, 65535));
            if0.in_valid = 1'b1;
            if0.in_data = d;
            #1;
            chk("mid_run_din", 32'(fdin0), 32'(d));
            exp_q0.push_back({1'b0, d + 16'h0101});
            if (i >= 2) exp_q1.push_back({1'b0, d + 16'h0101});
        end
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        if0.in_valid = 1'b0;
        @(negedge clk);
        #1;
        check_idle("mid_rst");
        chk("mid_rst_out_valid", 32'(if0.out_valid | if1.out_valid), 32'd0);
        chk("mid_rst_issued", 32'(cnt0), 32'd0);
        chk("mid_rst_underrun", 32'(under0), 32'd0);
        chk("mid_rst_queue0", 32'(exp_q0.size()), 32'd0);
        chk("mid_rst_queue1", 32'(exp_q1.size()), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_done", 32'(done0 | busy0), 32'd0);
        end
        run_case(vecs[0]);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
